// File: rtl/mips_inst_encoder.sv
// Streams MIPS instruction words for raw, move, ERET and 32/64-bit load-immediate
// requests, one word per out handshake, tagging each word with its byte address.
module mips_inst_encoder #(
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [5:0]  req_opcode,
  input  logic [5:0]  req_funct,
  input  logic [63:0] req_imm,
  input  logic        addr_load,
  input  logic [63:0] addr_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [63:0] out_addr,
  output logic        out_last,
  output logic        bad_kind
);

  localparam logic [2:0] K_RAW_R = 3'd0;
  localparam logic [2:0] K_RAW_I = 3'd1;
  localparam logic [2:0] K_RAW_J = 3'd2;
  localparam logic [2:0] K_MOVE  = 3'd3;
  localparam logic [2:0] K_LI32  = 3'd4;
  localparam logic [2:0] K_LI64  = 3'd5;
  localparam logic [2:0] K_ERET  = 3'd6;
  localparam logic [2:0] K_RSVD  = 3'd7;

  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_DSLL = 6'b111000;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  function automatic logic [2:0] word_count(input logic [2:0] kind, input logic [15:0] imm_hi);
    case (kind)
      K_LI32:  word_count = (imm_hi == 16'h0) ? 3'd1 : 3'd2;
      K_LI64:  word_count = 3'd6;
      K_RSVD:  word_count = 3'd0;
      default: word_count = 3'd1;
    endcase
  endfunction

  function automatic logic [31:0] encode(
    input logic [2:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  opcode,
    input logic [5:0]  funct,
    input logic [63:0] imm,
    input logic [2:0]  idx,
    input logic [2:0]  cnt
  );
    encode = 32'h0;
    case (kind)
      K_RAW_R: encode = {6'd0, rs, rt, rd, shamt, funct};
      K_RAW_I: encode = {opcode, rs, rt, imm[15:0]};
      K_RAW_J: encode = {opcode, imm[25:0]};
      K_MOVE:  encode = {6'd0, rs, 5'd0, rd, 5'd0, FN_ADDU};
      K_ERET:  encode = 32'h4200_0018;
      K_LI32: begin
        // A zero upper half collapses to a single ORI from $0.
        if (cnt == 3'd1)      encode = {OP_ORI, 5'd0, rt, imm[15:0]};
        else if (idx == 3'd0) encode = {OP_LUI, 5'd0, rt, imm[31:16]};
        else                  encode = {OP_ORI, rt, rt, imm[15:0]};
      end
      K_LI64: begin
        case (idx)
          3'd0:       encode = {OP_LUI, 5'd0, rt, imm[63:48]};
          3'd1:       encode = {OP_ORI, rt, rt, imm[47:32]};
          3'd2, 3'd4: encode = {6'd0, 5'd0, rt, rt, 5'd16, FN_DSLL};
          3'd3:       encode = {OP_ORI, rt, rt, imm[31:16]};
          default:    encode = {OP_ORI, rt, rt, imm[15:0]};
        endcase
      end
      default: encode = 32'h0;
    endcase
  endfunction

  state_t      state_q;
  logic [2:0]  kind_q;
  logic [4:0]  rs_q, rt_q, rd_q, shamt_q;
  logic [5:0]  opcode_q, funct_q;
  logic [63:0] imm_q;
  logic [2:0]  cnt_q, idx_q;
  logic [31:0] word_q;
  logic [63:0] addr_q;
  logic        last_q;
  logic        bad_q;

  logic [2:0]  cnt_d;
  logic [2:0]  idx_d;

  assign cnt_d = word_count(req_kind, req_imm[31:16]);
  assign idx_d = idx_q + 3'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      kind_q   <= 3'd0;
      rs_q     <= 5'd0;
      rt_q     <= 5'd0;
      rd_q     <= 5'd0;
      shamt_q  <= 5'd0;
      opcode_q <= 6'd0;
      funct_q  <= 6'd0;
      imm_q    <= 64'd0;
      cnt_q    <= 3'd0;
      idx_q    <= 3'd0;
      word_q   <= 32'd0;
      addr_q   <= BASE_ADDR;
      last_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      bad_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (addr_load) addr_q <= addr_value;
          if (req_valid) begin
            kind_q   <= req_kind;
            rs_q     <= req_rs;
            rt_q     <= req_rt;
            rd_q     <= req_rd;
            shamt_q  <= req_shamt;
            opcode_q <= req_opcode;
            funct_q  <= req_funct;
            imm_q    <= req_imm;
            cnt_q    <= cnt_d;
            idx_q    <= 3'd0;
            if (req_kind == K_RSVD) begin
              bad_q <= 1'b1;
            end else begin
              state_q <= EMIT;
              word_q  <= encode(req_kind, req_rs, req_rt, req_rd, req_shamt,
                                req_opcode, req_funct, req_imm, 3'd0, cnt_d);
              last_q  <= (cnt_d == 3'd1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            addr_q <= addr_q + 64'd4;
            idx_q  <= idx_d;
            if (last_q) begin
              state_q <= IDLE;
              last_q  <= 1'b0;
            end else begin
              word_q <= encode(kind_q, rs_q, rt_q, rd_q, shamt_q,
                               opcode_q, funct_q, imm_q, idx_d, cnt_q);
              last_q <= ((idx_d + 3'd1) == cnt_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_word  = word_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign bad_kind  = bad_q;

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Scoreboard bench: a word-list reference model fills an expected queue at issue time,
// and a negedge monitor pops and compares each handshaken word.
module tb_mips_inst_encoder;

  localparam logic [63:0] BASE = 64'h0;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
  logic [5:0]  req_opcode, req_funct;
  logic [63:0] req_imm;
  logic        addr_load;
  logic [63:0] addr_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [63:0] out_addr;
  logic        out_last;
  logic        bad_kind;

  mips_inst_encoder #(.BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
    .req_opcode(req_opcode), .req_funct(req_funct), .req_imm(req_imm),
    .addr_load(addr_load), .addr_value(addr_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .out_last(out_last), .bad_kind(bad_kind)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] w;
    logic [63:0] a;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          nrecv = 0;
  int          bad_seen = 0;
  int          bad_exp = 0;
  int          ready_mode = 0;  // 0 always ready, 1 random, 2 stalled
  logic [63:0] model_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Instruction builders written directly from the field layouts.
  function automatic logic [31:0] lui(input logic [31:0] rt, input logic [31:0] v);
    return 32'h3C00_0000 + (rt << 16) + (v & 32'hFFFF);
  endfunction
  function automatic logic [31:0] ori(input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] v);
    return 32'h3400_0000 + (rs << 21) + (rt << 16) + (v & 32'hFFFF);
  endfunction
  function automatic logic [31:0] dsll16(input logic [31:0] rt);
    return (rt << 16) + (rt << 11) + (32'd16 << 6) + 32'd56;
  endfunction

  always @(posedge clock) begin
    #1;
    if (ready_mode == 0)      out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
    else                      out_ready = 1'b0;
  end

  task automatic issue(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] op,
                       input logic [5:0] fn, input logic [63:0] imm,
                       input bit ld, input logic [63:0] lv);
    logic [31:0] ws[$];
    logic [31:0] r_s, r_t, r_d;
    int t;
    r_s = 32'(rs);
    r_t = 32'(rt);
    r_d = 32'(rd);
    t = 0;
    @(negedge clock);
    while (!req_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!req_ready) timeout_fail("issue_wait_ready");
    case (kind)
      0: ws.push_back((r_s << 21) + (r_t << 16) + (r_d << 11) + (32'(sh) << 6) + 32'(fn));
      1: ws.push_back((32'(op) << 26) + (r_s << 21) + (r_t << 16) + 32'(imm[15:0]));
      2: ws.push_back((32'(op) << 26) + 32'(imm[25:0]));
      3: ws.push_back((r_s << 21) + (r_d << 11) + 32'd33);
      4: begin
        if (imm[31:16] == 16'h0) ws.push_back(ori(0, r_t, 32'(imm[15:0])));
        else begin
          ws.push_back(lui(r_t, 32'(imm[31:16])));
          ws.push_back(ori(r_t, r_t, 32'(imm[15:0])));
        end
      end
      5: begin
        ws.push_back(lui(r_t, 32'(imm[63:48])));
        ws.push_back(ori(r_t, r_t, 32'(imm[47:32])));
        ws.push_back(dsll16(r_t));
        ws.push_back(ori(r_t, r_t, 32'(imm[31:16])));
        ws.push_back(dsll16(r_t));
        ws.push_back(ori(r_t, r_t, 32'(imm[15:0])));
      end
      6: ws.push_back(32'h4200_0018);
      default: bad_exp++;
    endcase
    if (ld) model_addr = lv;
    for (int i = 0; i < ws.size(); i++) begin
      exp_t e;
      e.w = ws[i];
      e.a = model_addr + 64'(4 * i);
      e.l = (i == ws.size() - 1);
      exp_q.push_back(e);
    end
    model_addr = model_addr + 64'(4 * ws.size());
    req_valid = 1'b1;
    req_kind = 3'(kind);
    req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh;
    req_opcode = op; req_funct = fn; req_imm = imm;
    addr_load = ld;
    addr_value = lv;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    addr_load = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 1000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 1000) timeout_fail(name);
  endtask

  // Monitor: compares every handshaken word and checks holding under stall.
  initial begin
    bit          held;
    logic [31:0] hw;
    logic [63:0] ha;
    logic        hl;
    exp_t        e;
    held = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        held = 1'b0;
      end else begin
        if (bad_kind) bad_seen++;
        chk("ready_vs_valid", req_ready, !out_valid);
        if (held) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_word", out_word, hw);
          chk("hold_addr", out_addr, ha);
          chk("hold_last", out_last, hl);
        end
        held = out_valid && !out_ready;
        hw = out_word;
        ha = out_addr;
        hl = out_last;
        if (!out_valid) chk("last_when_idle", out_last, 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%h expected=none", out_word);
          end else begin
            e = exp_q.pop_front();
            chk("word", out_word, e.w);
            chk("addr", out_addr, e.a);
            chk("last", out_last, e.l);
          end
          nrecv++;
        end
      end
    end
  end

  initial begin
    int target, t, kind;
    logic [63:0] imm;
    bit ld;
    reset = 1'b1;
    req_valid = 1'b0; req_kind = 3'd0;
    req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0; req_shamt = 5'd0;
    req_opcode = 6'd0; req_funct = 6'd0; req_imm = 64'd0;
    addr_load = 1'b0; addr_value = 64'd0;
    out_ready = 1'b1;
    model_addr = BASE;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_bad", bad_kind, 0);
    chk("rst_word", out_word, 0);
    chk("rst_addr", out_addr, BASE);
    chk("rst_ready", req_ready, 1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // LI32 split into LUI/ORI, then the single-ORI form.
    issue(4, 0, 8, 0, 0, 0, 0, 64'h1234_5678, 0, 0);
    drain("drain_li32");
    issue(4, 0, 2, 0, 0, 0, 0, 64'h0000_BEEF, 0, 0);
    drain("drain_li32s");
    chk("addr_after_li32s", out_addr, 64'd12);

    issue(5, 0, 8, 0, 0, 0, 0, 64'h1111_2222_3333_4444, 0, 0);
    drain("drain_li64");

    // MOVE with a stalled consumer.
    ready_mode = 2;
    issue(3, 4, 0, 3, 0, 0, 0, 64'd0, 0, 0);
    repeat (3) @(negedge clock);
    chk("move_stalled_valid", out_valid, 1);
    ready_mode = 0;
    drain("drain_move");

    // Address wrap, then a reserved kind.
    issue(6, 0, 0, 0, 0, 0, 0, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    drain("drain_eret");
    chk("addr_wrap", out_addr, 64'd0);
    issue(7, 1, 2, 3, 4, 5, 6, 64'hDEAD, 0, 0);
    @(negedge clock);
    chk("bad_pulse", bad_kind, 1);
    chk("bad_no_valid", out_valid, 0);
    @(negedge clock);
    chk("bad_clear", bad_kind, 0);
    chk("bad_addr_kept", out_addr, 64'd0);

    // Standalone preload honoured in IDLE, ignored during a burst.
    @(negedge clock);
    addr_load = 1'b1;
    addr_value = 64'h0000_0000_0040_0000;
    @(posedge clock);
    #1 addr_load = 1'b0;
    model_addr = 64'h0000_0000_0040_0000;
    ready_mode = 1;
    issue(5, 0, 17, 0, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 0, 0);
    @(negedge clock);
    addr_load = 1'b1;
    addr_value = 64'hAAAA_0000_0000_0000;
    @(negedge clock);
    addr_load = 1'b0;
    drain("drain_ignore_load");
    ready_mode = 0;

    // Reset in the middle of an LI64 burst.
    issue(5, 0, 9, 0, 0, 0, 0, 64'h5555_6666_7777_8888, 0, 0);
    target = nrecv + 2;
    t = 0;
    while (nrecv < target && t < 100) begin
      @(posedge clock);
      t++;
    end
    if (nrecv < target) timeout_fail("mid_burst_wait");
    #1 reset = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_addr", out_addr, BASE);
    chk("midrst_last", out_last, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_addr = BASE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_rst_idle", out_valid, 0);
      chk("post_rst_ready", req_ready, 1);
    end

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      ready_mode = $urandom_range(0, 1);
      kind = $urandom_range(0, 7);
      imm = {$urandom(), $urandom()};
      if (kind == 4 && $urandom_range(0, 1) == 0) imm[31:16] = 16'h0;
      ld = ($urandom_range(0, 7) == 0);
      issue(kind, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            6'($urandom), 6'($urandom), imm, ld, {$urandom(), $urandom()} & ~64'h3);
    end
    drain("drain_random");
    repeat (2) @(negedge clock);
    chk("bad_kind_count", bad_seen, bad_exp);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
